sdx_kernel_addwm_job_ctrl: RTL
==============================

# sdx_kernel_addwm_job_ctrl

Job sequencer that sits directly downstream of the kernel's AXI4-Lite control register block. It consumes ap_start and the argument registers (p00..p11, axi00_im, axi01_wm). It launches the image-read, watermark-read and result-write channels of the add-watermark datapath, waits for all three to finish, and reports ap_done/ap_idle back to the register block. It owns no data path; it only latches arguments, derives transfer sizes and sequences handshakes.

## Interface
- C_ADDR_WIDTH, 64: width of AXI byte addresses driven to the channels.
- C_LEN_WIDTH, 34: width of byte-count outputs; pixel count × 4 bytes.
- aclk  in  1  kernel clock.
- areset_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  level from the register block; held high until the cycle after ap_done.
- ap_idle  out  1  high while in IDLE.
- ap_done  out  1  single-cycle completion pulse.
- p00  in  32  image pixel count (32-bit pixels).
- p01  in  32  watermark pixel count; 0 means no watermark.
- p10, p11  in  32 each  blend coefficients alpha and beta, passed through.
- axi00_im  in  64  image base address; source and in-place destination.
- axi01_wm  in  64  watermark base address.
- rd_im_start, rd_wm_start, wr_start  out  1 each  single-cycle launch pulses.
- rd_im_addr, rd_wm_addr, wr_addr  out  C_ADDR_WIDTH each  latched base addresses.
- rd_im_bytes, rd_wm_bytes, wr_bytes  out  C_LEN_WIDTH each  latched byte counts.
- rd_im_done, rd_wm_done, wr_done  in  1 each  single-cycle completion pulses from the channels.
- dp_alpha, dp_beta  out  32 each  latched p10 and p11.
- perf_cycles  out  32  cycles consumed by the last job (see Configuration).

## Operation
- States: IDLE, LAUNCH, BUSY, DONE.
- IDLE:
  - When ap_start=1, latch all arguments on the clock edge.
  - Byte counts are {p, 2'b00}, zero-extended to C_LEN_WIDTH. wr_bytes = rd_im_bytes. wr_addr = axi00_im.
  - If p00==0, go straight to DONE. Otherwise go to LAUNCH.
- LAUNCH:
  - Assert rd_im_start and wr_start for one cycle.
  - Assert rd_wm_start only if p01!=0. If p01==0, preset the wm done flag.
  - Go to BUSY.
- BUSY:
  - Keep three sticky done flags, one per channel; each sets on its done pulse.
  - When all three are set (including flags set that same cycle), go to DONE.
  - Duplicate done pulses are harmless.
- DONE:
  - ap_done=1 for exactly one cycle; clear the flags; go to IDLE.
  - The register block clears ap_start on this edge, so IDLE never re-triggers from a stale start.
- Done pulses received in IDLE, LAUNCH or DONE are ignored. Channels do not respond in the same cycle as their start pulse.
- Argument outputs hold their latched values until the next job is latched. Register changes during a job have no effect.
- Reset (asynchronous, any state):
  - State returns to IDLE; all flags and start pulses clear.
  - All address, byte, coefficient and perf outputs go to 0; ap_done=0; ap_idle=1.
  - Channels share the same reset, so no in-flight transfer survives.

## Timing
- ap_start is sampled at edge 0. From edge 0:
  - Cycle 1: LAUNCH; start pulses high.
  - Cycle 2: BUSY.
  - Last done pulse in cycle k: ap_done high in cycle k+1; ap_idle high from cycle k+2.
- Zero-length job: ap_done in cycle 1, with no start pulses.
- ap_idle is a decode of the state register; there are no combinational paths from inputs to outputs.
- Minimum job turnaround (IDLE to IDLE): 2 cycles for a zero-length job, 4 cycles otherwise.

## Configuration
- ADDWM_JOB_CTRL_PERF_EN defined:
  - perf_cycles counts every cycle from LAUNCH through DONE inclusive, saturating at 32'hFFFF_FFFF.
  - The counter clears when a new job is latched and holds its value in IDLE.
  - A zero-length job reports 1.
- ADDWM_JOB_CTRL_PERF_EN undefined: the port remains present and is tied to 0; no counter logic is instantiated.

## Structure
- Shared package addwm_pkg holds:
  - the state enum (IDLE, LAUNCH, BUSY, DONE);
  - LP_BYTES_PER_PIX=4;
  - the default C_LEN_WIDTH.
- One sub-module: addwm_done_tracker. It contains the three sticky flags with preset, clear and all_done logic, and is instantiated once.

## Test plan
- p00=16, p01=4, addresses 0x1000/0x2000:
  - Expect rd_im_bytes=64, rd_wm_bytes=16, wr_addr=0x1000, with all three start pulses in cycle 1.
  - Dones in cycles 5, 7 and 9 → ap_done in cycle 10, ap_idle from cycle 11.
- p00=0 → ap_done in cycle 1, no start pulses; perf_cycles=1 with the macro defined.
- p00=8, p01=0 → no rd_wm_start; rd_im_done and wr_done in the same cycle 6 → ap_done in cycle 7.
- Reset asserted in BUSY:
  - Expect an immediate ap_idle=1 and all outputs 0.
  - A later ap_start runs a fresh job with no residual flags.
- Stray wr_done in IDLE, then a job where only rd_im_done and rd_wm_done arrive → stays in BUSY and ap_done is never asserted.
- p00 changed mid-job → rd_im_bytes is unchanged until the next launch.

Source files
------------

// File: rtl/addwm_pkg.sv
// Shared types and constants for the add-watermark job controller.
package addwm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StBusy,
        StDone
    } job_state_e;

    localparam int unsigned LP_BYTES_PER_PIX = 4;
    localparam int unsigned LP_LEN_WIDTH     = 34;
    localparam int unsigned LP_PIX_SHIFT     = $clog2(LP_BYTES_PER_PIX);

    // Pixel count to byte count: {pix, 2'b00} zero-extended.
    function automatic logic [LP_LEN_WIDTH-1:0] pix_to_bytes(input logic [31:0] pix);
        return LP_LEN_WIDTH'(pix) << LP_PIX_SHIFT;
    endfunction

endpackage

// File: rtl/addwm_done_tracker.sv
// Sticky per-channel completion flags (image read, watermark read, result write).
module addwm_done_tracker (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic preset_wm_i,
    input  logic clear_i,
    input  logic im_done_i,
    input  logic wm_done_i,
    input  logic wr_done_i,
    output logic all_done_o
);

    // Bit order: {wr, wm, im}.
    logic [2:0] flags_q, flags_d;
    logic [2:0] pulses;

    assign pulses = {wr_done_i, wm_done_i, im_done_i};

    always_comb begin
        flags_d = flags_q;
        if (clear_i) begin
            flags_d = 3'b000;
        end else begin
            if (preset_wm_i) begin
                flags_d[1] = 1'b1;
            end
            if (en_i) begin
                flags_d = flags_d | pulses;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Includes pulses arriving this cycle so BUSY can exit without an extra cycle.
    assign all_done_o = &(flags_q | (en_i ? pulses : 3'b000));

endmodule

// File: rtl/sdx_kernel_addwm_job_ctrl.sv
// Job sequencer for the add-watermark kernel: latches arguments, launches the three channels,
// waits for their completion. Optional cycle counter enabled by ADDWM_JOB_CTRL_PERF_EN.
module sdx_kernel_addwm_job_ctrl
    import addwm_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_LEN_WIDTH  = LP_LEN_WIDTH
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic                    ap_start,
    output logic                    ap_idle,
    output logic                    ap_done,
    input  logic [31:0]             p00,
    input  logic [31:0]             p01,
    input  logic [31:0]             p10,
    input  logic [31:0]             p11,
    input  logic [63:0]             axi00_im,
    input  logic [63:0]             axi01_wm,
    output logic                    rd_im_start,
    output logic                    rd_wm_start,
    output logic                    wr_start,
    output logic [C_ADDR_WIDTH-1:0] rd_im_addr,
    output logic [C_ADDR_WIDTH-1:0] rd_wm_addr,
    output logic [C_ADDR_WIDTH-1:0] wr_addr,
    output logic [C_LEN_WIDTH-1:0]  rd_im_bytes,
    output logic [C_LEN_WIDTH-1:0]  rd_wm_bytes,
    output logic [C_LEN_WIDTH-1:0]  wr_bytes,
    input  logic                    rd_im_done,
    input  logic                    rd_wm_done,
    input  logic                    wr_done,
    output logic [31:0]             dp_alpha,
    output logic [31:0]             dp_beta,
    output logic [31:0]             perf_cycles
);

    job_state_e              state_q, state_d;
    logic                    latch;
    logic                    all_done;
    logic [C_ADDR_WIDTH-1:0] im_addr_q, im_addr_d, wm_addr_q, wm_addr_d;
    logic [C_LEN_WIDTH-1:0]  im_bytes_q, im_bytes_d, wm_bytes_q, wm_bytes_d;
    logic [31:0]             alpha_q, alpha_d, beta_q, beta_d;
    logic                    wm_en_q, wm_en_d;

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        case (state_q)
            StIdle: begin
                if (ap_start) begin
                    latch   = 1'b1;
                    state_d = (p00 == 32'd0) ? StDone : StLaunch;
                end
            end
            StLaunch: state_d = StBusy;
            StBusy: begin
                if (all_done) begin
                    state_d = StDone;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        im_addr_d  = im_addr_q;
        wm_addr_d  = wm_addr_q;
        im_bytes_d = im_bytes_q;
        wm_bytes_d = wm_bytes_q;
        alpha_d    = alpha_q;
        beta_d     = beta_q;
        wm_en_d    = wm_en_q;
        if (latch) begin
            im_addr_d  = C_ADDR_WIDTH'(axi00_im);
            wm_addr_d  = C_ADDR_WIDTH'(axi01_wm);
            im_bytes_d = C_LEN_WIDTH'(pix_to_bytes(p00));
            wm_bytes_d = C_LEN_WIDTH'(pix_to_bytes(p01));
            alpha_d    = p10;
            beta_d     = p11;
            wm_en_d    = (p01 != 32'd0);
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= StIdle;
            im_addr_q  <= '0;
            wm_addr_q  <= '0;
            im_bytes_q <= '0;
            wm_bytes_q <= '0;
            alpha_q    <= '0;
            beta_q     <= '0;
            wm_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            im_addr_q  <= im_addr_d;
            wm_addr_q  <= wm_addr_d;
            im_bytes_q <= im_bytes_d;
            wm_bytes_q <= wm_bytes_d;
            alpha_q    <= alpha_d;
            beta_q     <= beta_d;
            wm_en_q    <= wm_en_d;
        end
    end

    addwm_done_tracker u_done_tracker (
        .clk_i       (aclk),
        .rst_ni      (areset_n),
        .en_i        (state_q == StBusy),
        .preset_wm_i ((state_q == StLaunch) && !wm_en_q),
        .clear_i     (state_q == StDone),
        .im_done_i   (rd_im_done),
        .wm_done_i   (rd_wm_done),
        .wr_done_i   (wr_done),
        .all_done_o  (all_done)
    );

    // All outputs decode registered state only.
    assign ap_idle     = (state_q == StIdle);
    assign ap_done     = (state_q == StDone);
    assign rd_im_start = (state_q == StLaunch);
    assign wr_start    = (state_q == StLaunch);
    assign rd_wm_start = (state_q == StLaunch) && wm_en_q;
    assign rd_im_addr  = im_addr_q;
    assign wr_addr     = im_addr_q;
    assign rd_wm_addr  = wm_addr_q;
    assign rd_im_bytes = im_bytes_q;
    assign wr_bytes    = im_bytes_q;
    assign rd_wm_bytes = wm_bytes_q;
    assign dp_alpha    = alpha_q;
    assign dp_beta     = beta_q;

`ifdef ADDWM_JOB_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (latch) begin
            perf_d = 32'd0;
        end else if ((state_q != StIdle) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
